uart_capture: RTL and testbench

Synthesizable UART receiver that consumes the serial stream produced by the bench-side UART launch device. It resolves each 8N1 frame on an `RXD` input and buffers the recovered bytes in a small FIFO. The FIFO is drained over a valid/ready interface. The block is the DUT-side counterpart of the launcher: launcher `TXD` drives `RXD` directly, and the launcher is clocked at the bit rate while this block runs at `CLKS_PER_BIT` times that rate.

---
 rtl/uart_capture.sv | 149 ++++++++++++++
 tb/tb_uart_capture.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_capture.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// small circular receive FIFO drained over a valid/ready handshake.
module uart_capture #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          RXD,
  output logic [7:0]                    RX_DATA,
  output logic                          RX_VALID,
  input  logic                          RX_READY,
  output logic                          FRAME_ERR,
  output logic                          OVERRUN,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic          sync1, rxs, rxs_prev;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, fe_n, ov_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, full;

  assign full       = (count == DEPTH_C);
  assign RX_VALID   = (count != '0);
  assign pop        = RX_VALID && RX_READY;
  assign RX_DATA    = RX_VALID ? mem[rd_ptr] : 8'h00;
  assign FIFO_COUNT = count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      rxs_prev  <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      sync1     <= RXD;
      rxs       <= sync1;
      rxs_prev  <= rxs;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      FRAME_ERR <= fe_n;
      OVERRUN   <= ov_n;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    fe_n      = 1'b0;
    ov_n      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (rxs_prev && !rxs) state_n = S_START;
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n     = '0;
          shreg_n   = {rxs, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          if (!rxs) begin
            fe_n    = 1'b1;
            state_n = S_WAIT_IDLE;
          end else if (!full || pop) begin
            push = 1'b1;
          end else begin
            ov_n = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_n = '0;
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: storage array is not reset; the count and pointers alone define
  // which entries are live.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_capture.sv
// Self-checking bench for uart_capture: directed scenarios plus random frames,
// compared every cycle against a sample-time/queue model of the receiver.
module tb_uart_capture;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int HLEN  = 131072;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RXD;
  logic       RX_READY = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_VALID, FRAME_ERR, OVERRUN;
  logic [$clog2(DEPTH):0] FIFO_COUNT;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int ready_mode = 0;   // 0 low, 1 high, 2 toggle, 3 random
  logic [7:0] popped_q[$];

  uart_capture #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .RXD(RXD),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[e] is the RXD level the DUT captures on edge e; the receiver sees it
  // two edges later. Frames are resolved by reading hist at the sample times.
  bit         hist [HLEN];
  int         cyc = 0;
  int         mode = 0;      // 0 idle, 1 in frame, 2 waiting for line high
  int         s_edge = 0;
  int         det_from = 0;
  logic [7:0] mq[$];
  bit         m_fe = 0, m_ov = 0;

  initial foreach (hist[i]) hist[i] = 1'b1;

  always @(posedge CLK) begin
    logic [7:0] b;
    m_fe = 0;
    m_ov = 0;
    if (RESET) begin
      hist[cyc] = 1'b1;
      if (cyc >= 2) begin hist[cyc-1] = 1'b1; hist[cyc-2] = 1'b1; end
      mq.delete();
      mode = 0;
      det_from = cyc + 1;
    end else begin
      hist[cyc] = RXD;
      if (RX_READY && mq.size() > 0) void'(mq.pop_front());
      case (mode)
        0: if (cyc >= 3 && cyc >= det_from && hist[cyc-3] && !hist[cyc-2]) begin
             mode = 1;
             s_edge = cyc + CPB / 2;
           end
        1: begin
             if (cyc == s_edge && hist[cyc-2]) begin
               mode = 0;
               det_from = cyc + 1;
             end else if (cyc == s_edge + 9 * CPB) begin
               for (int n = 0; n < 8; n++) b[n] = hist[s_edge + CPB * (n + 1) - 2];
               if (hist[cyc-2]) begin
                 if (mq.size() < DEPTH) mq.push_back(b);
                 else m_ov = 1;
                 mode = 0;
                 det_from = cyc + 1;
               end else begin
                 m_fe = 1;
                 mode = 2;
               end
             end
           end
        default: if (hist[cyc-2]) begin
                   mode = 0;
                   det_from = cyc + 1;
                 end
      endcase
    end
    cyc++;
  end

  // Single compare process, away from the active edge.
  always @(negedge CLK) begin
    check("rx_valid", RX_VALID, (mq.size() > 0));
    check("rx_data", RX_DATA, (mq.size() > 0) ? mq[0] : 8'h00);
    check("fifo_count", FIFO_COUNT, mq.size());
    check("frame_err", FRAME_ERR, m_fe);
    check("overrun", OVERRUN, m_ov);
    if (FRAME_ERR) fe_cnt++;
    if (OVERRUN) ov_cnt++;
    if (RX_VALID && RX_READY) popped_q.push_back(RX_DATA);
  end

  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0: RX_READY = 1'b0;
      1: RX_READY = 1'b1;
      2: RX_READY = ~RX_READY;
      default: RX_READY = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    RXD = v;
    repeat (n) tick();
  endtask

  // Launcher: one bit per CPB receiver clocks; abort_at >= 0 pulses RESET
  // (line released high) after that many clocks and returns.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_at);
    logic [9:0] bits;
    int n;
    bits = {stop_bit, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        if (n == abort_at) begin
          RXD = 1'b1;
          RESET = 1'b1;
          tick();
          RESET = 1'b0;
          return;
        end
        RXD = bits[i];
        tick();
        n++;
      end
    end
    RXD = 1'b1;
  endtask

  task automatic drain();
    ready_mode = 1;
    hold(1'b1, DEPTH + 6);
    ready_mode = 0;
    hold(1'b1, 3);
  endtask

  initial begin
    logic [7:0] hello [5];
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
    RXD = 1'b1;
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    hold(1'b1, 5);
    check("reset_valid", RX_VALID, 0);
    check("reset_count", FIFO_COUNT, 0);
    check("reset_data", RX_DATA, 0);

    // Single byte
    send_frame(8'h41, 1'b1, -1);
    hold(1'b1, 12);
    check("single_valid", RX_VALID, 1);
    check("single_data", RX_DATA, 8'h41);
    check("single_count", FIFO_COUNT, 1);

    // Glitch rejection: short low must not start a frame
    hold(1'b0, 4);
    hold(1'b1, 30);
    check("glitch_count", FIFO_COUNT, 1);
    check("glitch_fe", fe_cnt, 0);
    drain();
    check("drain1_count", FIFO_COUNT, 0);

    // Framing error followed by a break, then a good frame
    send_frame(8'h55, 1'b0, -1);
    hold(1'b0, 40);
    hold(1'b1, 20);
    send_frame(8'h0F, 1'b1, -1);
    hold(1'b1, 12);
    check("break_fe_pulses", fe_cnt, 1);
    check("break_count", FIFO_COUNT, 1);
    check("break_data", RX_DATA, 8'h0F);
    drain();

    // Overrun: ninth frame into a full FIFO is dropped
    popped_q.delete();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, -1);
    hold(1'b1, 12);
    check("ovr_count", FIFO_COUNT, DEPTH);
    check("ovr_pulses", ov_cnt, 1);
    drain();
    check("ovr_drained", popped_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (i < popped_q.size()) check("ovr_order", popped_q[i], 8'(i + 1));

    // Reset during bit 4 of 8'hA5 with a byte already buffered
    send_frame(8'h77, 1'b1, -1);
    hold(1'b1, 12);
    check("pre_reset_count", FIFO_COUNT, 1);
    send_frame(8'hA5, 1'b1, 5 * CPB + CPB / 2);
    check("mid_reset_valid", RX_VALID, 0);
    check("mid_reset_data", RX_DATA, 0);
    check("mid_reset_count", FIFO_COUNT, 0);
    hold(1'b1, 20);
    send_frame(8'h3C, 1'b1, -1);
    hold(1'b1, 12);
    check("post_reset_count", FIFO_COUNT, 1);
    check("post_reset_data", RX_DATA, 8'h3C);
    check("post_reset_fe", fe_cnt, 1);
    check("post_reset_ov", ov_cnt, 1);
    drain();

    // Back-to-back "HELLO", consumer ready toggling every cycle
    popped_q.delete();
    ready_mode = 2;
    for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1, -1);
    hold(1'b1, 40);
    ready_mode = 0;
    check("hello_len", popped_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < popped_q.size()) check("hello_byte", popped_q[i], hello[i]);
    check("hello_fe", fe_cnt, 1);

    // Random frames, stop errors, glitches, gaps and consumer stalls
    ready_mode = 3;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        hold(1'b0, $urandom_range(1, 5));
        hold(1'b1, $urandom_range(4, 12));
      end
      send_frame(8'($urandom), ($urandom_range(0, 7) != 0), -1);
      hold(1'b1, $urandom_range(0, 24));
    end
    hold(1'b1, 20);
    drain();
    check("final_count", FIFO_COUNT, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
